// File: rtl/shift_exec_stage.sv
// Two-deep valid/ready wrapper around an external combinational 18-bit shifter.
// Stage A holds the issued op and drives the shifter; stage B captures the result for writeback.
module shift_exec_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [17:0]      in_s1,
    input  logic [17:0]      in_s2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [17:0]      sh_s1,
    output logic [17:0]      sh_s2,
    output logic [1:0]       sh_op,
    input  logic [17:0]      sh_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [17:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] stat_count
);

    localparam logic [1:0] OP_ILL = 2'd1;

    function automatic logic is_illegal(input logic [1:0] op);
        return (op == OP_ILL);
    endfunction

    logic             r_a_valid;
    logic [1:0]       r_a_op;
    logic [17:0]      r_a_s1;
    logic [17:0]      r_a_s2;
    logic [TAG_W-1:0] r_a_tag;

    logic             r_b_valid;
    logic [17:0]      r_b_res;
    logic [TAG_W-1:0] r_b_tag;
    logic             r_b_err;
    logic [CNT_W-1:0] r_stat_count;

    logic w_b_free;
    logic w_a_adv;
    logic w_in_xfer;
    logic w_out_xfer;

    // Handshake and advance conditions for both stages
    always_comb begin
        w_b_free   = !r_b_valid || out_ready;
        w_a_adv    = r_a_valid && w_b_free;
        in_ready   = !rst && !flush && (!r_a_valid || w_b_free);
        w_in_xfer  = in_valid && in_ready;
        w_out_xfer = r_b_valid && out_ready;
    end

    // Shifter sees stage A only while it holds a live op, otherwise a quiet zero
    always_comb begin
        sh_s1 = 18'd0;
        sh_s2 = 18'd0;
        sh_op = 2'd0;
        if (r_a_valid) begin
            sh_s1 = r_a_s1;
            sh_s2 = r_a_s2;
            sh_op = r_a_op;
        end else begin
            sh_s1 = 18'd0;
            sh_s2 = 18'd0;
            sh_op = 2'd0;
        end
    end

    // Stage A: accept from issue, empty when the op moves on with nothing behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_op    <= 2'd0;
            r_a_s1    <= 18'd0;
            r_a_s2    <= 18'd0;
            r_a_tag   <= {TAG_W{1'b0}};
        end else if (flush) begin
            r_a_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_a_valid <= 1'b1;
            r_a_op    <= in_op;
            r_a_s1    <= in_s1;
            r_a_s2    <= in_s2;
            r_a_tag   <= in_tag;
        end else if (w_a_adv) begin
            r_a_valid <= 1'b0;
        end else begin
            r_a_valid <= r_a_valid;
        end
    end

    // Stage B: capture shifter result (zeroed for illegal ops) and present to writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_res   <= 18'd0;
            r_b_tag   <= {TAG_W{1'b0}};
            r_b_err   <= 1'b0;
        end else if (flush) begin
            r_b_valid <= 1'b0;
        end else if (w_a_adv) begin
            r_b_valid <= 1'b1;
            r_b_res   <= is_illegal(r_a_op) ? 18'd0 : sh_res;
            r_b_tag   <= r_a_tag;
            r_b_err   <= is_illegal(r_a_op);
        end else if (w_out_xfer) begin
            r_b_valid <= 1'b0;
        end else begin
            r_b_valid <= r_b_valid;
        end
    end

    // Completed-transfer counter; a transfer in a flush cycle still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_count <= {CNT_W{1'b0}};
        end else if (w_out_xfer) begin
            r_stat_count <= r_stat_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stat_count <= r_stat_count;
        end
    end

    assign out_valid  = r_b_valid;
    assign out_res    = r_b_res;
    assign out_tag    = r_b_tag;
    assign out_err    = r_b_err;
    assign stat_count = r_stat_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Randomized and directed bench for shift_exec_stage against a queue-based transaction model.
// The bench also plays the role of the external combinational shifter.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [17:0] in_s1 = 18'd0;
    logic [17:0] in_s2 = 18'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        flush = 1'b0;
    logic [17:0] sh_s1;
    logic [17:0] sh_s2;
    logic [1:0]  sh_op;
    logic [17:0] sh_res;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_res;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [15:0] stat_count;

    shift_exec_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_s1(in_s1), .in_s2(in_s2), .in_tag(in_tag),
        .flush(flush), .sh_s1(sh_s1), .sh_s2(sh_s2), .sh_op(sh_op),
        .sh_res(sh_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
        .stat_count(stat_count)
    );

    always #5 clk = ~clk;

    // Shift semantics from plain arithmetic: amounts >= 18 saturate
    function automatic logic [17:0] ref_shift(input logic [1:0] op, input logic [17:0] a,
                                              input logic [17:0] n);
        logic [17:0] r;
        int amt;
        amt = (n >= 18'd18) ? 18 : int'(n);
        case (op)
            2'd0:    r = (amt >= 18) ? 18'd0 : (a << amt);
            2'd2:    r = (amt >= 18) ? 18'd0 : (a >> amt);
            2'd3:    r = (amt >= 18) ? {18{a[17]}} : 18'($signed(a) >>> amt);
            default: r = 18'h2AAAA ^ a;
        endcase
        return r;
    endfunction

    assign sh_res = ref_shift(sh_op, sh_s1, sh_s2);

    typedef struct {
        logic [17:0] res;
        logic [3:0]  tag;
        logic        err;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [17:0] xlog[$];
    logic [15:0] cnt = 16'd0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [17:0] last_res;
    logic        last_err;
    int          last_xfer_cyc;
    int          last_acc_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 60)
                $display("FAIL %s actual=%h required=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare just after, advance the model at posedge
    task automatic step(input bit iv, input logic [1:0] op, input logic [17:0] s1,
                        input logic [17:0] s2, input logic [3:0] tg, input bit fl,
                        input bit ordy, input bit rs, output bit acc);
        bit   exp_ir;
        bit   exp_ov;
        ent_t e;
        @(negedge clk);
        in_valid = iv; in_op = op; in_s1 = s1; in_s2 = s2; in_tag = tg;
        flush = fl; out_ready = ordy; rst = rs;
        #1;
        exp_ir = !rs && !fl && (q.size() < 2 || ordy);
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_res", {14'd0, out_res}, {14'd0, q[0].res});
            chk("out_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
            chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
        end
        chk("stat_count", {16'd0, stat_count}, {16'd0, cnt});
        if (q.size() == 0) begin
            chk("sh_s1_idle", {14'd0, sh_s1}, 32'd0);
            chk("sh_s2op_idle", {12'd0, sh_op, sh_s2}, 32'd0);
        end
        acc = iv && exp_ir;
        @(posedge clk);
        if (rs) begin
            q.delete();
            cnt = 16'd0;
        end else begin
            if (exp_ov && ordy) begin
                xlog.push_back(out_res);
                last_res = out_res;
                last_err = out_err;
                last_xfer_cyc = cyc;
                void'(q.pop_front());
                cnt = cnt + 16'd1;
            end
            if (acc) begin
                e.err = (op == 2'd1);
                e.res = e.err ? 18'd0 : ref_shift(op, s1, s2);
                e.tag = tg;
                e.acc = cyc;
                q.push_back(e);
                last_acc_cyc = cyc;
            end
            if (fl) q.delete();
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 18'd0, 18'd0, 4'd0, 1'b0, ordy, 1'b0, a);
    endtask

    task automatic issue(input logic [1:0] op, input logic [17:0] s1, input logic [17:0] s2,
                         input logic [3:0] tg, input bit ordy);
        bit a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            step(1'b1, op, s1, s2, tg, 1'b0, ordy, 1'b0, a);
            tries++;
        end
        chk("issue_timeout", {31'd0, a}, 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        #1;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_res"}, {14'd0, out_res}, 32'd0);
        chk({tag, "_tag"}, {28'd0, out_tag}, 32'd0);
        chk({tag, "_err"}, {31'd0, out_err}, 32'd0);
        chk({tag, "_stat"}, {16'd0, stat_count}, 32'd0);
    endtask

    initial begin
        bit          a;
        int          idx;
        logic [17:0] rs2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b0, 2'd0, 18'd0, 18'd0, 4'd0, 1'b0, 1'b1, 1'b1, a);
        chk_zero_outputs("reset");

        // Basic latency and value
        issue(2'd0, 18'h00001, 18'd4, 4'd3, 1'b1);
        idle(3, 1'b1);
        chk("shl_res", {14'd0, last_res}, 32'h10);
        chk("shl_latency", last_xfer_cyc - last_acc_cyc, 32'd2);

        // Saturating shift amounts
        issue(2'd3, 18'h20000, 18'd17, 4'd1, 1'b1);
        idle(3, 1'b1);
        chk("sar17", {14'd0, last_res}, 32'h3FFFF);
        issue(2'd3, 18'h20000, 18'd40, 4'd2, 1'b1);
        idle(3, 1'b1);
        chk("sar40", {14'd0, last_res}, 32'h3FFFF);
        issue(2'd2, 18'h3FFFF, 18'd18, 4'd4, 1'b1);
        idle(3, 1'b1);
        chk("shr18", {14'd0, last_res}, 32'h0);

        // Illegal op then a legal one
        issue(2'd1, 18'h12345, 18'd1, 4'd5, 1'b1);
        idle(3, 1'b1);
        chk("ill_err", {31'd0, last_err}, 32'd1);
        chk("ill_res", {14'd0, last_res}, 32'd0);
        issue(2'd0, 18'h00003, 18'd1, 4'd6, 1'b1);
        idle(3, 1'b1);
        chk("legal_err", {31'd0, last_err}, 32'd0);

        // Backpressure: only two ops buffered, then strict order on release
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(idx < 4, 2'd0, 18'(idx + 1), 18'd1, 4'(idx), 1'b0, 1'b0, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_accepted", idx, 32'd2);
        xlog.delete();
        for (int i = 0; i < 10; i++) begin
            step(idx < 4, 2'd0, 18'(idx + 1), 18'd1, 4'(idx), 1'b0, 1'b1, 1'b0, a);
            if (a) idx++;
        end
        chk("bp_count", xlog.size(), 32'd4);
        for (int i = 0; i < 4 && i < xlog.size(); i++)
            chk("bp_order", {14'd0, xlog[i]}, 32'(2 * (i + 1)));

        // Flush kills both in-flight ops
        issue(2'd0, 18'h00011, 18'd2, 4'd7, 1'b0);
        issue(2'd0, 18'h00022, 18'd2, 4'd8, 1'b0);
        step(1'b1, 2'd0, 18'h1, 18'd1, 4'd9, 1'b1, 1'b0, 1'b0, a);
        xlog.delete();
        issue(2'd2, 18'h00100, 18'd4, 4'd10, 1'b1);
        idle(4, 1'b1);
        chk("flush_count", xlog.size(), 32'd1);
        chk("flush_res", {14'd0, last_res}, 32'h10);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rs2 = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 20));
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 18'($urandom), rs2,
                 4'($urandom), $urandom_range(0, 99) < 3, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0, a);
        end

        // Counter wrap: stream until 0xFFFE completions, then two more
        while (cnt != 16'hFFFE)
            step(1'b1, 2'($urandom_range(0, 3)), 18'($urandom), 18'($urandom_range(0, 20)),
                 4'($urandom), 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 2; i++)
            step(1'b1, 2'd0, 18'h5, 18'd1, 4'd1, 1'b0, 1'b1, 1'b0, a);
        idle(1, 1'b0);
        chk("stat_wrap", {16'd0, stat_count}, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd3, 18'h2F0F0, 18'd3, 4'hC, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 2'd0, 18'h1, 18'd1, 4'd1, 1'b0, 1'b1, 1'b1, a);
        chk_zero_outputs("midrst");
        idle(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
